// File: rtl/mcpnr_serial_pkg.sv
// Shared definitions for the one-wire redstone serial link (transmitter and future receiver).
// Line polarity: the line idles low and a frame opens with a high start bit.
package mcpnr_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Counter/index width that stays at least one bit even for a count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcpnr_tick_counter.sv
// Bit-period timer: counts 0..TICKS-1 and flags the last cycle of each bit period.
// Holding clr keeps the count at zero so a new period starts cleanly.
module mcpnr_tick_counter
  import mcpnr_serial_pkg::*;
#(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_o
);

  localparam int CNT_W = cnt_width(TICKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick_o) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/mcpnr_serial_tx.sv
// Bit-serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Each bit is held TICKS_PER_BIT cycles so that slow redstone repeaters can settle.
module mcpnr_serial_tx
  import mcpnr_serial_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int TICKS_PER_BIT = 4,
  parameter int PARITY        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int IDX_W = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [IDX_W-1:0] idx;
  logic             par_bit;
  logic             tick;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // The bit timer restarts on every slot change: it is held clear in IDLE and
  // wraps on its own terminal tick, which is exactly when the FSM moves on.
  mcpnr_tick_counter #(
    .TICKS(TICKS_PER_BIT)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick_o(tick)
  );

  assign shreg_nxt = shreg >> 1;
  assign ready_o   = (state == IDLE);
  assign busy_o    = (state != IDLE);

  // tx_o is loaded with the value of the slot being entered, so the line
  // changes on the same edge as the state and never depends on inputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      par_bit <= 1'b0;
      tx_o    <= LINE_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            shreg   <= data_i;
            par_bit <= even_parity(data_i);
            idx     <= '0;
            tx_o    <= START_BIT;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            idx   <= '0;
            tx_o  <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
              if (PARITY != 0) begin
                tx_o  <= par_bit;
                state <= PAR;
              end else begin
                tx_o  <= STOP_BIT;
                state <= STOP;
              end
            end else begin
              shreg <= shreg_nxt;
              idx   <= idx + IDX_W'(1);
              tx_o  <= shreg_nxt[0];
            end
          end
        end
        PAR: begin
          if (tick) begin
            tx_o  <= STOP_BIT;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            tx_o  <= LINE_IDLE;
            state <= IDLE;
          end
        end
        default: begin
          tx_o  <= LINE_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpnr_serial_tx.sv
// Scoreboard bench for mcpnr_serial_tx: three configurations (8/4/no parity, 8/4/parity, 8/1/no parity).
// Stimulus pushes the expected per-cycle line values; a negedge monitor pops them while a DUT is busy.
module tb_mcpnr_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data [3];
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [2:0] busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int   d;
    logic v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mcpnr_serial_tx #(.WIDTH(8), .TICKS_PER_BIT(4), .PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));

  mcpnr_serial_tx #(.WIDTH(8), .TICKS_PER_BIT(4), .PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));

  mcpnr_serial_tx #(.WIDTH(8), .TICKS_PER_BIT(1), .PARITY(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_i(data[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_slot(input int d, input logic v, input int ticks);
    exp_t e;
    e.d = d;
    e.v = v;
    for (int t = 0; t < ticks; t++) exp_q.push_back(e);
  endtask

  // Expected line: start(1), data LSB first, optional hand-supplied parity, stop(0).
  task automatic push_frame(input int d, input logic [7:0] w, input int ticks,
                            input bit use_par, input logic par);
    push_slot(d, 1'b1, ticks);
    for (int i = 0; i < 8; i++) push_slot(d, w[i], ticks);
    if (use_par) push_slot(d, par, ticks);
    push_slot(d, 1'b0, ticks);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the accepting edge.
  task automatic send(input int d, input logic [7:0] w, input int ticks,
                      input bit use_par, input logic par);
    push_frame(d, w, ticks, use_par, par);
    data[d]  = w;
    valid[d] = 1'b1;
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
  endtask

  // Counts rising edges until ready returns; bounded so a stuck DUT still reaches the summary.
  task automatic cycles_to_ready(input int d, output int n);
    n = 0;
    while (!ready[d] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        if (busy[d]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL txbit dut%0d: tx=%0b while nothing was expected", d, tx[d]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.d != d || tx[d] !== mon_e.v) begin
              fails++;
              $display("FAIL txbit dut%0d: tx=%0b, expected %0b (entry for dut%0d)",
                       d, tx[d], mon_e.v, mon_e.d);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    bit seen_idle;

    rst_n = 1'b0;
    valid = '0;
    for (int d = 0; d < 3; d++) data[d] = '0;
    #2;
    check("reset_state", {tx, ready, busy}, {3'b000, 3'b111, 3'b000});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with no valid: line low, ready high, not busy.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("idle_dut0", {tx[0], ready[0], busy[0]}, 3'b010);
      check("idle_tx_all", tx, 3'b000);
    end

    // 8'hA5, 4 ticks, no parity: 40-cycle frame, ready back 40 edges after acceptance.
    send(0, 8'hA5, 4, 1'b0, 1'b0);
    check("busy_after_accept", busy[0], 1'b1);
    check("tx_start_immediate", tx[0], 1'b1);
    cycles_to_ready(0, n);
    check("ready_return_a5", n, 40);

    // Parity config, valid held: 8'h07 (parity 1) then 8'h03 (parity 0), starts 45 apart.
    push_frame(1, 8'h07, 4, 1'b1, 1'b1);
    push_frame(1, 8'h03, 4, 1'b1, 1'b0);
    data[1]  = 8'h07;
    valid[1] = 1'b1;
    @(posedge clk);
    #1;
    data[1] = 8'h03;
    check("par_first_accept", busy[1], 1'b1);
    gap = 0;
    seen_idle = 1'b0;
    while (gap < 200) begin
      @(posedge clk);
      #1;
      gap++;
      if (!busy[1]) seen_idle = 1'b1;
      else if (seen_idle) break;
    end
    valid[1] = 1'b0;
    check("start_spacing", gap, 45);
    cycles_to_ready(1, n);
    check("par_second_len", n, 44);

    // One tick per bit: 8'hFF gives nine ones then a zero.
    send(2, 8'hFF, 1, 1'b0, 1'b0);
    cycles_to_ready(2, n);
    check("ticks1_len", n, 10);

    // Input churn during a frame must not disturb the latched 8'h3C.
    send(0, 8'h3C, 4, 1'b0, 1'b0);
    n = 0;
    while (busy[0] && n < 200) begin
      data[0]  = 8'($urandom);
      valid[0] = 1'($urandom_range(0, 1));
      check("ready_low_while_busy", ready[0], 1'b0);
      @(posedge clk);
      #1;
      n++;
    end
    valid[0] = 1'b0;
    check("churn_frame_len", n, 40);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_extra_frame", {ready[0], busy[0]}, 2'b10);
    end

    // Reset in the bit-3 slot of 8'h5A (bit 3 is a one), then a clean 8'h81.
    send(0, 8'h5A, 4, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    #2;
    check("pre_reset_bit3", tx[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_tx_async", tx[0], 1'b0);
    check("reset_ready_busy", {ready[0], busy[0]}, 2'b10);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_held_idle", {tx[0], busy[0]}, 2'b00);
    rst_n = 1'b1;
    send(0, 8'h81, 4, 1'b0, 1'b0);
    check("post_reset_accept", busy[0], 1'b1);
    cycles_to_ready(0, n);
    check("post_reset_len", n, 40);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
